// File: rtl/mcpu_dbus_ctrl.sv
// Data-bus controller between the core data port and NSLV memory-mapped slaves.
// Decodes the slave select, runs a registered request/ack handshake and reports unmapped and timed-out accesses.
module mcpu_dbus_ctrl #(
    parameter int          NSLV     = 4,
    parameter int          SEL_LSB  = 28,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic [31:0]          DADDR,
    input  logic [31:0]          DATAO,
    input  logic [3:0]           BE,
    input  logic                 WR,
    input  logic                 RD,
    output logic [31:0]          DATAI,
    output logic                 HLT,
    output logic [NSLV-1:0]      S_SEL,
    output logic [31:0]          S_ADDR,
    output logic [31:0]          S_WDATA,
    output logic [3:0]           S_BE,
    output logic                 S_WR,
    output logic                 S_RD,
    input  logic [NSLV*32-1:0]   S_RDATA,
    input  logic [NSLV-1:0]      S_ACK,
    output logic                 BUS_ERR,
    output logic [31:0]          ERR_ADDR,
    output logic [7:0]           ERR_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0]  NSLV_W   = 5'(NSLV);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [31:0]       datai_q, datai_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [3:0]        req_idx_s;
    logic              mapped_s;
    logic [NSLV-1:0]   req_sel_s;
    logic              ack_sel_s;
    logic [31:0]       rdata_sel_s;

    assign req_idx_s = DADDR[SEL_LSB+3:SEL_LSB];
    assign mapped_s  = ({1'b0, req_idx_s} < NSLV_W);
    assign HLT       = (RD | WR) & (state_q != ST_DONE);

    // Slave decode of the request and ack/read-data muxing by the registered index.
    always_comb begin
        req_sel_s   = '0;
        ack_sel_s   = 1'b0;
        rdata_sel_s = 32'h0000_0000;
        for (int i = 0; i < NSLV; i++) begin
            req_sel_s[i] = (req_idx_s == 4'(i));
            if (idx_q == 4'(i)) begin
                ack_sel_s   = S_ACK[i];
                rdata_sel_s = S_RDATA[i*32 +: 32];
            end else begin
                ack_sel_s   = ack_sel_s;
                rdata_sel_s = rdata_sel_s;
            end
        end
    end

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        datai_d    = datai_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (RD | WR) begin
                    addr_d  = DADDR;
                    wdata_d = DATAO;
                    be_d    = BE;
                    idx_d   = req_idx_s;
                    if (mapped_s) begin
                        sel_d   = req_sel_s;
                        wr_d    = WR;
                        rd_d    = RD & ~WR;
                        tmo_d   = 16'd0;
                        state_d = ST_BUSY;
                    end else begin
                        // Unmapped: complete at once with an error, no strobes.
                        state_d    = ST_DONE;
                        bus_err_d  = 1'b1;
                        err_addr_d = DADDR;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        if (RD & ~WR) begin
                            datai_d = 32'h0000_0000;
                        end else begin
                            datai_d = datai_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                tmo_d = tmo_q + 16'd1;
                if (ack_sel_s) begin
                    if (rd_q) begin
                        datai_d = rdata_sel_s;
                    end else begin
                        datai_d = datai_q;
                    end
                    sel_d   = '0;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    if (rd_q) begin
                        datai_d = ERR_DATA;
                    end else begin
                        datai_d = datai_q;
                    end
                    sel_d      = '0;
                    wr_d       = 1'b0;
                    rd_d       = 1'b0;
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    err_cnt_d  = sat_inc(err_cnt_q);
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            tmo_q      <= 16'd0;
            datai_q    <= 32'h0000_0000;
            sel_q      <= '0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'h0000_0000;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            datai_q    <= datai_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign DATAI    = datai_q;
    assign S_SEL    = sel_q;
    assign S_ADDR   = addr_q;
    assign S_WDATA  = wdata_q;
    assign S_BE     = be_q;
    assign S_WR     = wr_q;
    assign S_RD     = rd_q;
    assign BUS_ERR  = bus_err_q;
    assign ERR_ADDR = err_addr_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_mcpu_dbus_ctrl.sv
// Self-checking bench for mcpu_dbus_ctrl: table of accesses driven through a slave model,
// expected completions queued on drive and compared when the access retires.
module tb_mcpu_dbus_ctrl;

    localparam int NSLV    = 4;
    localparam int TIMEOUT = 8;

    logic                CLK = 1'b0;
    logic                RES;
    logic [31:0]         DADDR, DATAO, DATAI, S_ADDR, S_WDATA, ERR_ADDR;
    logic [3:0]          BE, S_BE;
    logic                WR, RD, HLT, S_WR, S_RD, BUS_ERR;
    logic [NSLV-1:0]     S_SEL, S_ACK;
    logic [NSLV*32-1:0]  S_RDATA;
    logic [7:0]          ERR_CNT;

    always #5 CLK = ~CLK;

    mcpu_dbus_ctrl #(
        .NSLV(NSLV), .SEL_LSB(28), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .CLK(CLK), .RES(RES), .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .WR(WR), .RD(RD),
        .DATAI(DATAI), .HLT(HLT), .S_SEL(S_SEL), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA),
        .S_BE(S_BE), .S_WR(S_WR), .S_RD(S_RD), .S_RDATA(S_RDATA), .S_ACK(S_ACK),
        .BUS_ERR(BUS_ERR), .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_after;   // ack on this strobe cycle; 0 = never
        logic        noise;       // neighbour slave acks while waiting
        logic [31:0] ack_data;
        logic [31:0] exp_datai;
        logic        exp_err;
        int          exp_hlt;
    } vec_t;

    typedef struct {
        logic [31:0] datai;
        logic        err;
        logic [31:0] err_addr;
        logic [7:0]  err_cnt;
        int          hlt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  cnt_m = 8'd0;
    logic [31:0] eaddr_m = 32'h0;
    logic [NSLV*32-1:0] junk_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    vec_t        tbl[8];
    vec_t        v_sat, v_after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v);
        exp_t            e, g;
        logic [3:0]      idx;
        logic            mapped;
        int              slv, hlt_n, strobes, guard;
        logic [NSLV-1:0] esel;
        idx    = v.addr[31:28];
        mapped = (idx < 4'(NSLV));
        slv    = int'(idx);
        esel   = '0;
        if (mapped) esel[slv] = 1'b1;
        if (v.exp_err) begin
            cnt_m   = (cnt_m == 8'hFF) ? cnt_m : cnt_m + 8'd1;
            eaddr_m = v.addr;
        end
        e.datai = v.exp_datai; e.err = v.exp_err; e.err_addr = eaddr_m;
        e.err_cnt = cnt_m; e.hlt = v.exp_hlt;
        sb_q.push_back(e);

        @(negedge CLK);
        DADDR = v.addr; DATAO = v.wdata; BE = v.be; RD = v.rd; WR = v.wr;
        S_ACK = '0; S_RDATA = junk_rdata;
        #1;
        hlt_n = 0; strobes = 0; guard = 0;
        while (HLT === 1'b1 && guard < 200) begin
            hlt_n++; guard++;
            @(negedge CLK);
            S_ACK = '0; S_RDATA = junk_rdata;
            if (S_SEL !== '0) begin
                strobes++;
                check("s_sel", 32'(S_SEL), 32'(esel));
                check("s_addr", S_ADDR, v.addr);
                check("s_wdata", S_WDATA, v.wdata);
                check("s_be", 32'(S_BE), 32'(v.be));
                check("s_wr", 32'(S_WR), 32'(v.wr));
                check("s_rd", 32'(S_RD), 32'(v.rd & ~v.wr));
                if (v.ack_after == strobes) begin
                    S_ACK[slv] = 1'b1;
                    S_RDATA[slv*32 +: 32] = v.ack_data;
                end else if (v.noise) begin
                    S_ACK[(slv + 1) % NSLV] = 1'b1;
                end
            end
            #1;
        end
        if (guard >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL hlt_stuck: got HLT=%b expected 0 within 200 cycles", HLT);
        end
        check("strobe_cycles", 32'(strobes), 32'(v.exp_hlt - 1));
        check("sel_drop", 32'(S_SEL), 32'h0);
        check("wr_drop", 32'(S_WR), 32'h0);
        check("rd_drop", 32'(S_RD), 32'h0);
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            g = sb_q.pop_front();
            check("hlt_cycles", 32'(hlt_n), 32'(g.hlt));
            check("datai", DATAI, g.datai);
            check("bus_err", 32'(BUS_ERR), 32'(g.err));
            check("err_addr", ERR_ADDR, g.err_addr);
            check("err_cnt", 32'(ERR_CNT), 32'(g.err_cnt));
        end
        RD = 1'b0; WR = 1'b0; S_ACK = '0;
        @(negedge CLK);
        #1;
        check("bus_err_pulse_end", 32'(BUS_ERR), 32'h0);
        check("hlt_idle", 32'(HLT), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rd    wr    addr           wdata          be       ack nz    ack_data       exp_datai      err   hlt
        tbl[0] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0000_0000, 4'b1111, 1, 1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 2};
        tbl[1] = '{1'b0, 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 5, 1'b1, 32'h5555_5555, 32'hCAFE_0001, 1'b0, 6};
        tbl[2] = '{1'b1, 1'b0, 32'h7000_0000, 32'h0000_0000, 4'b1111, 0, 1'b0, 32'h0,          32'h0000_0000, 1'b1, 1};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'b1111, 0, 1'b1, 32'h0,          32'hDEAD_BEEF, 1'b1, 9};
        tbl[4] = '{1'b0, 1'b1, 32'h3000_0008, 32'hAAAA_5555, 4'b1111, 3, 1'b0, 32'h9999_9999, 32'hDEAD_BEEF, 1'b0, 4};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 4'b1000, 2, 1'b0, 32'h7777_7777, 32'hDEAD_BEEF, 1'b0, 3};
        tbl[6] = '{1'b1, 1'b0, 32'h3000_0000, 32'h0000_0000, 4'b1111, 8, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 9};
        tbl[7] = '{1'b0, 1'b1, 32'hF000_0000, 32'h1111_2222, 4'b0001, 0, 1'b0, 32'h0,          32'h0BAD_F00D, 1'b1, 1};
        v_sat   = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 9};
        v_after = '{1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'b1111, 2, 1'b0, 32'h3333_CCCC, 32'h3333_CCCC, 1'b0, 3};

        RES = 1'b0; RD = 1'b0; WR = 1'b0; DADDR = 32'h0; DATAO = 32'h0; BE = 4'h0;
        S_ACK = '0; S_RDATA = junk_rdata;
        #1;
        check("rst_datai", DATAI, 32'h0);
        check("rst_hlt", 32'(HLT), 32'h0);
        check("rst_sel", 32'(S_SEL), 32'h0);
        check("rst_addr", S_ADDR, 32'h0);
        check("rst_wdata", S_WDATA, 32'h0);
        check("rst_be", 32'(S_BE), 32'h0);
        check("rst_strobes", 32'({S_WR, S_RD}), 32'h0);
        check("rst_bus_err", 32'(BUS_ERR), 32'h0);
        check("rst_err_addr", ERR_ADDR, 32'h0);
        check("rst_err_cnt", 32'(ERR_CNT), 32'h0);
        repeat (2) @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        #1;
        check("idle_hlt", 32'(HLT), 32'h0);
        check("idle_sel", 32'(S_SEL), 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_access(tbl[i]);
        end

        for (int i = 0; i < 300; i++) begin
            run_access(v_sat);
        end
        check("err_cnt_saturated", 32'(ERR_CNT), 32'd255);

        // Abort a read to slave 1 while it is waiting for ack.
        @(negedge CLK);
        DADDR = 32'h1000_0000; RD = 1'b1; WR = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("abort_pre_sel", 32'(S_SEL), 32'h2);
        RES = 1'b0; RD = 1'b0;
        #1;
        check("abort_sel", 32'(S_SEL), 32'h0);
        check("abort_rd", 32'(S_RD), 32'h0);
        check("abort_hlt", 32'(HLT), 32'h0);
        check("abort_err_cnt", 32'(ERR_CNT), 32'h0);
        check("abort_datai", DATAI, 32'h0);
        @(negedge CLK);
        RES = 1'b1;
        cnt_m = 8'd0; eaddr_m = 32'h0;
        run_access(v_after);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_dbus_ctrl.md
Name: mcpu_dbus_ctrl

Overview:
Parametrised data-bus controller placed between the RISC-V core's data port and NSLV memory-mapped slaves: data RAM, UART, timers and so on. It decodes the CPU address into a slave select and runs a registered request/ack handshake with each slave. While an access is outstanding it stalls the core through HLT. Unmapped accesses and slave timeouts complete with an error response instead of hanging the core.

Parameters:
NSLV, 4, number of slave channels (1..16)
SEL_LSB, 28, lowest DADDR bit of the slave-select field; the field is 4 bits wide, DADDR[SEL_LSB+3:SEL_LSB]
TIMEOUT, 255, BUSY cycles without ack before the access is aborted (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
DADDR  in  32  CPU data address
DATAO  in  32  CPU write data
BE  in  4  CPU byte enables
WR  in  1  CPU write request
RD  in  1  CPU read request
DATAI  out  32  read data to CPU
HLT  out  1  stall to CPU
S_SEL  out  NSLV  one-hot slave select
S_ADDR  out  32  latched address
S_WDATA  out  32  latched write data
S_BE  out  4  latched byte enables
S_WR  out  1  write strobe
S_RD  out  1  read strobe
S_RDATA  in  NSLV*32  per-slave read data; slave i drives bits [32i+31:32i]
S_ACK  in  NSLV  per-slave acknowledge
BUS_ERR  out  1  one-cycle error pulse
ERR_ADDR  out  32  address of the last errored access
ERR_CNT  out  8  saturating error count

Behaviour:
- Reset (RES=0, asynchronous):
  - state=IDLE
  - DATAI, S_ADDR, S_WDATA, ERR_ADDR = 0
  - S_SEL, S_BE, S_WR, S_RD, BUS_ERR = 0
  - ERR_CNT = 0; timeout counter = 0
  - Reset mid-access drops the access; no ack is expected afterwards.
- States: IDLE, BUSY, DONE.
- HLT is combinational: HLT = (RD|WR) & (state != DONE). Consequences:
  - the core stalls in the same cycle it raises a request;
  - HLT=0 whenever RD=WR=0.
- IDLE, with RD|WR=1 at the clock edge:
  - latch DADDR, DATAO and BE;
  - idx = DADDR[SEL_LSB+3:SEL_LSB].
  - If idx < NSLV:
    - S_SEL = one-hot(idx);
    - S_WR = WR; S_RD = RD & ~WR (WR has priority when both are set);
    - clear the timeout counter and go to BUSY.
  - If idx >= NSLV (unmapped):
    - no strobes are issued; go to DONE with an error;
    - a read returns DATAI = 0.
- BUSY:
  - S_SEL, S_ADDR, S_WDATA, S_BE, S_WR and S_RD are held stable.
  - The timeout counter increments every cycle.
  - On S_ACK[idx]=1:
    - a read registers DATAI = S_RDATA slice idx; a write leaves DATAI unchanged;
    - strobes and S_SEL drop to 0 and the state goes to DONE.
  - Acks from unselected slaves, and any ack outside BUSY, are ignored.
  - Timeout: counter reaches TIMEOUT with no ack:
    - a read sets DATAI = ERR_DATA;
    - strobes drop, error is raised, state goes to DONE;
    - an ack arriving in that same cycle takes priority over the timeout.
- Error event (unmapped access or timeout), all registered, taking effect on entry to DONE:
  - BUS_ERR=1 for exactly one cycle;
  - ERR_ADDR = latched address;
  - ERR_CNT increments and saturates at 255.
- DONE: lasts one cycle with HLT=0, so the core retires the access. The state then returns to IDLE. A request held in the following cycle starts a new access.
- Latency from the request edge:
  - strobes are visible 1 cycle later;
  - a slave acking in its first strobe cycle gives HLT high for 2 cycles and completion in cycle 3;
  - each cycle of slave wait adds 1.
- Width rules:
  - S_RDATA is sliced by the registered idx;
  - DATAO, BE and DADDR pass through unmodified, with no byte-lane shifting.

Test Plan:
1. Reset then idle: RES pulse low, RD=WR=0 -> all outputs 0, HLT=0, state IDLE.
2. Zero-wait read: RD=1, DADDR=32'h1000_0010 (idx 1), slave1 acks on its first strobe cycle with 32'hCAFE0001 -> S_SEL=4'b0010, HLT=1 for 2 cycles, DATAI=32'hCAFE0001 when HLT falls, BUS_ERR stays 0.
3. Waited write: WR=1, BE=4'b0011, DADDR=32'h2000_0004, DATAO=32'h1234_5678, slave2 acks after 5 strobe cycles -> S_WDATA, S_BE and S_ADDR stable for all 5 cycles, HLT=1 for 6 cycles, DATAI unchanged.
4. Unmapped access (NSLV=4): RD=1, DADDR=32'h7000_0000 -> no strobe, DATAI=0, BUS_ERR pulse, ERR_ADDR=32'h7000_0000, ERR_CNT=1.
5. Timeout (TIMEOUT=8): read to slave0, no ack -> DATAI=32'hDEADBEEF after 8 BUSY cycles, BUS_ERR pulse, ERR_CNT increments; 300 further timeouts leave ERR_CNT=255.
6. Abort: RES driven low during BUSY, then released -> strobes clear immediately; the next read to slave3 completes normally with correct data.
